// File: rtl/cam_mem_pkg.sv
// Shared types and constants for the camera frame controller and its DRAM command arbiter.
package cam_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAM_CALIB,
        ST_CAM_INIT,
        ST_CAPTURE,
        ST_DRAIN,
        ST_SEND
    } cam_state_t;

    localparam logic [2:0]  CMD_WRITE      = 3'd0;
    localparam logic [2:0]  CMD_READ       = 3'd1;
    localparam logic [29:0] DEFAULT_STRIDE = 30'h0010_0000;

    // Buffer-index width; a single buffer still needs a 1-bit port.
    function automatic int buf_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cam_cmd_arb.sv
// Two-slot DRAM command arbiter: one pending slot per source (0 = write, 1 = read), write has priority.
module cam_cmd_arb
    import cam_mem_pkg::*;
#(
    parameter int ADDR_W = 30,
    parameter int BL_W   = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              w_en,
    input  logic [BL_W-1:0]   w_bl,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic              r_en,
    input  logic [BL_W-1:0]   r_bl,
    input  logic [ADDR_W-1:0] r_addr,
    input  logic              cmd_full,
    output logic              cmd_en,
    output logic [2:0]        cmd_inst,
    output logic [BL_W-1:0]   cmd_bl,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic              cmd_ovf
);

    logic [1:0]        src_en;
    logic [BL_W-1:0]   src_bl    [2];
    logic [ADDR_W-1:0] src_addr  [2];
    logic [BL_W-1:0]   slot_bl   [2];
    logic [ADDR_W-1:0] slot_addr [2];
    logic [1:0]        pend;
    logic [1:0]        issue;
    logic [1:0]        drop;
    logic              cmd_ovf_reg;

    assign src_en      = {r_en, w_en};
    assign src_bl[0]   = w_bl;
    assign src_bl[1]   = r_bl;
    assign src_addr[0] = w_addr;
    assign src_addr[1] = r_addr;

    assign issue[0] = ~cmd_full & pend[0];
    assign issue[1] = ~cmd_full & pend[1] & ~pend[0];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            logic              valid_reg;
            logic [BL_W-1:0]   bl_reg;
            logic [ADDR_W-1:0] addr_reg;

            // A slot being issued this cycle may be refilled on the same edge.
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_reg <= 1'b0;
                    bl_reg    <= '0;
                    addr_reg  <= '0;
                end else if (src_en[gi] && (!valid_reg || issue[gi])) begin
                    valid_reg <= 1'b1;
                    bl_reg    <= src_bl[gi];
                    addr_reg  <= src_addr[gi];
                end else if (issue[gi]) begin
                    valid_reg <= 1'b0;
                end
            end

            assign pend[gi]      = valid_reg;
            assign drop[gi]      = src_en[gi] & valid_reg & ~issue[gi];
            assign slot_bl[gi]   = bl_reg;
            assign slot_addr[gi] = addr_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_ovf_reg <= 1'b0;
        end else if (|drop) begin
            cmd_ovf_reg <= 1'b1;
        end
    end

    // Slots still hold stale requests during the reset cycle, so suppress issue there.
    always_comb begin
        cmd_en   = 1'b0;
        cmd_inst = CMD_WRITE;
        cmd_bl   = '0;
        cmd_addr = '0;
        if (!reset && issue[0]) begin
            cmd_en   = 1'b1;
            cmd_bl   = slot_bl[0];
            cmd_addr = slot_addr[0];
        end else if (!reset && issue[1]) begin
            cmd_en   = 1'b1;
            cmd_inst = CMD_READ;
            cmd_bl   = slot_bl[1];
            cmd_addr = slot_addr[1];
        end
    end

    assign cmd_ovf = cmd_ovf_reg;

endmodule

// File: rtl/cam_frame_ctrl.sv
// Camera frame controller: bring-up sequencing, capture/readback FSM over a DRAM buffer ring.
// Optional frame counters are enabled by defining CAM_FRAME_CTRL_STATS_EN.
module cam_frame_ctrl
    import cam_mem_pkg::*;
#(
    parameter int                ADDR_W     = 30,
    parameter int                BL_W       = 6,
    parameter int                NUM_BUF    = 2,
    parameter logic [ADDR_W-1:0] BUF_STRIDE = ADDR_W'(DEFAULT_STRIDE),
    parameter int                CONTINUOUS = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             calib_done,
    output logic                             ram_reset,
    output logic                             i2c_reset,
    input  logic                             i2c_done,
    input  logic                             click,
    output logic                             begin_cap,
    input  logic                             done_cap,
    input  logic                             w_cmd_en,
    input  logic [BL_W-1:0]                  w_cmd_bl,
    input  logic [ADDR_W-1:0]                w_cmd_addr,
    output logic                             begin_read,
    input  logic                             read_done,
    input  logic                             r_cmd_en,
    input  logic [BL_W-1:0]                  r_cmd_bl,
    input  logic [ADDR_W-1:0]                r_cmd_addr,
    input  logic                             cmd_full,
    output logic                             cmd_en,
    output logic [2:0]                       cmd_inst,
    output logic [BL_W-1:0]                  cmd_bl,
    output logic [ADDR_W-1:0]                cmd_addr,
    output logic [buf_width(NUM_BUF)-1:0]    wr_buf,
    output logic [buf_width(NUM_BUF)-1:0]    rd_buf,
    output logic                             cmd_ovf
`ifdef CAM_FRAME_CTRL_STATS_EN
    ,
    output logic [15:0]                      frames_captured,
    output logic [15:0]                      frames_sent
`endif
);

    localparam int   BUF_W    = buf_width(NUM_BUF);
    localparam logic CONT_CAP = (CONTINUOUS != 0) && (NUM_BUF > 1);

    cam_state_t        state_reg;
    logic              ram_reset_reg;
    logic              i2c_reset_reg;
    logic              begin_cap_reg;
    logic              begin_read_reg;
    logic [BUF_W-1:0]  wr_buf_reg;
    logic [BUF_W-1:0]  rd_buf_reg;
    logic [BUF_W-1:0]  wr_buf_next;
    logic [ADDR_W-1:0] w_full_addr;
    logic [ADDR_W-1:0] r_full_addr;

    assign wr_buf_next = (wr_buf_reg == BUF_W'(NUM_BUF - 1)) ? '0 : wr_buf_reg + BUF_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            ram_reset_reg  <= 1'b1;
            i2c_reset_reg  <= 1'b0;
            begin_cap_reg  <= 1'b0;
            begin_read_reg <= 1'b0;
            wr_buf_reg     <= '0;
            rd_buf_reg     <= '0;
        end else begin
            i2c_reset_reg <= 1'b0;
            unique case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg     <= ST_RAM_CALIB;
                        ram_reset_reg <= 1'b0;
                        i2c_reset_reg <= 1'b1;
                    end
                end
                ST_RAM_CALIB: begin
                    if (calib_done) state_reg <= ST_CAM_INIT;
                end
                ST_CAM_INIT: begin
                    if (i2c_done) begin
                        state_reg     <= ST_CAPTURE;
                        begin_cap_reg <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (click) begin
                        state_reg     <= ST_DRAIN;
                        begin_cap_reg <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // Hand the finished buffer to readback and move capture to the next one.
                    if (done_cap) begin
                        state_reg      <= ST_SEND;
                        rd_buf_reg     <= wr_buf_reg;
                        wr_buf_reg     <= wr_buf_next;
                        begin_read_reg <= 1'b1;
                        begin_cap_reg  <= CONT_CAP;
                    end
                end
                ST_SEND: begin
                    if (read_done) begin
                        state_reg      <= ST_CAPTURE;
                        begin_read_reg <= 1'b0;
                        begin_cap_reg  <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef CAM_FRAME_CTRL_STATS_EN
    logic [15:0] frames_captured_reg;
    logic [15:0] frames_sent_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            frames_captured_reg <= '0;
            frames_sent_reg     <= '0;
        end else begin
            if (state_reg == ST_DRAIN && done_cap) frames_captured_reg <= frames_captured_reg + 16'd1;
            if (state_reg == ST_SEND && read_done) frames_sent_reg <= frames_sent_reg + 16'd1;
        end
    end

    assign frames_captured = frames_captured_reg;
    assign frames_sent     = frames_sent_reg;
`endif

    assign ram_reset  = ram_reset_reg;
    assign i2c_reset  = i2c_reset_reg;
    assign begin_cap  = begin_cap_reg;
    assign begin_read = begin_read_reg;
    assign wr_buf     = wr_buf_reg;
    assign rd_buf     = rd_buf_reg;

    // Offsets become absolute addresses using the buffer current at request time.
    assign w_full_addr = ADDR_W'(wr_buf_reg) * BUF_STRIDE + w_cmd_addr;
    assign r_full_addr = ADDR_W'(rd_buf_reg) * BUF_STRIDE + r_cmd_addr;

    cam_cmd_arb #(
        .ADDR_W (ADDR_W),
        .BL_W   (BL_W)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .w_en     (w_cmd_en),
        .w_bl     (w_cmd_bl),
        .w_addr   (w_full_addr),
        .r_en     (r_cmd_en),
        .r_bl     (r_cmd_bl),
        .r_addr   (r_full_addr),
        .cmd_full (cmd_full),
        .cmd_en   (cmd_en),
        .cmd_inst (cmd_inst),
        .cmd_bl   (cmd_bl),
        .cmd_addr (cmd_addr),
        .cmd_ovf  (cmd_ovf)
    );

endmodule

// File: tb/tb_cam_frame_ctrl.sv
// Directed self-checking bench for cam_frame_ctrl (default parameters, NUM_BUF=2).
module tb_cam_frame_ctrl;
    import cam_mem_pkg::*;

    localparam int ADDR_W = 30;
    localparam int BL_W   = 6;

    logic              clk = 1'b0;
    logic              reset, start, calib_done, ram_reset, i2c_reset, i2c_done;
    logic              click, begin_cap, done_cap, w_cmd_en, begin_read, read_done, r_cmd_en;
    logic [BL_W-1:0]   w_cmd_bl, r_cmd_bl, cmd_bl;
    logic [ADDR_W-1:0] w_cmd_addr, r_cmd_addr, cmd_addr;
    logic              cmd_full, cmd_en, cmd_ovf;
    logic [2:0]        cmd_inst;
    logic [0:0]        wr_buf, rd_buf;
`ifdef CAM_FRAME_CTRL_STATS_EN
    logic [15:0]       frames_captured, frames_sent;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cam_frame_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .calib_done (calib_done),
        .ram_reset  (ram_reset),
        .i2c_reset  (i2c_reset),
        .i2c_done   (i2c_done),
        .click      (click),
        .begin_cap  (begin_cap),
        .done_cap   (done_cap),
        .w_cmd_en   (w_cmd_en),
        .w_cmd_bl   (w_cmd_bl),
        .w_cmd_addr (w_cmd_addr),
        .begin_read (begin_read),
        .read_done  (read_done),
        .r_cmd_en   (r_cmd_en),
        .r_cmd_bl   (r_cmd_bl),
        .r_cmd_addr (r_cmd_addr),
        .cmd_full   (cmd_full),
        .cmd_en     (cmd_en),
        .cmd_inst   (cmd_inst),
        .cmd_bl     (cmd_bl),
        .cmd_addr   (cmd_addr),
        .wr_buf     (wr_buf),
        .rd_buf     (rd_buf),
        .cmd_ovf    (cmd_ovf)
`ifdef CAM_FRAME_CTRL_STATS_EN
        ,
        .frames_captured (frames_captured),
        .frames_sent     (frames_sent)
`endif
    );

    // Advance to 2 time units after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        #1;
        n_cmp++; if (ram_reset !== 1'b1) begin n_err++; $display("FAIL rst_ram_reset: got %b want 1", ram_reset); end
        n_cmp++; if (i2c_reset !== 1'b0) begin n_err++; $display("FAIL rst_i2c_reset: got %b want 0", i2c_reset); end
        n_cmp++; if (begin_cap !== 1'b0) begin n_err++; $display("FAIL rst_begin_cap: got %b want 0", begin_cap); end
        n_cmp++; if (begin_read !== 1'b0) begin n_err++; $display("FAIL rst_begin_read: got %b want 0", begin_read); end
        n_cmp++; if (cmd_en !== 1'b0) begin n_err++; $display("FAIL rst_cmd_en: got %b want 0", cmd_en); end
        n_cmp++; if (cmd_ovf !== 1'b0) begin n_err++; $display("FAIL rst_cmd_ovf: got %b want 0", cmd_ovf); end
        n_cmp++; if (wr_buf !== 1'b0 || rd_buf !== 1'b0) begin n_err++; $display("FAIL rst_bufs: got wr=%0d rd=%0d want 0/0", wr_buf, rd_buf); end
        reset = 1'b0;
        cyc();
        #1;
        n_cmp++; if (dut.state_reg !== ST_IDLE) begin n_err++; $display("FAIL rst_state: got %0d want %0d", dut.state_reg, ST_IDLE); end
        n_cmp++; if (ram_reset !== 1'b1) begin n_err++; $display("FAIL idle_ram_reset: got %b want 1", ram_reset); end
        $display("reset: state=%0d ram_reset=%b", dut.state_reg, ram_reset);
    endtask

    task automatic test_bringup();
        int pulses;
        start = 1'b1;
        cyc();
        start = 1'b0;
        #1;
        n_cmp++; if (ram_reset !== 1'b0) begin n_err++; $display("FAIL bring_ram_reset: got %b want 0", ram_reset); end
        n_cmp++; if (i2c_reset !== 1'b1) begin n_err++; $display("FAIL bring_i2c_entry: got %b want 1", i2c_reset); end
        pulses = int'(i2c_reset);
        for (int i = 0; i < 10; i++) begin
            cyc();
            pulses += int'(i2c_reset);
        end
        calib_done = 1'b1;
        cyc();
        calib_done = 1'b0;
        pulses += int'(i2c_reset);
        i2c_done = 1'b1;
        cyc();
        i2c_done = 1'b0;
        #1;
        pulses += int'(i2c_reset);
        n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL bring_i2c_pulses: got %0d want 1", pulses); end
        n_cmp++; if (dut.state_reg !== ST_CAPTURE) begin n_err++; $display("FAIL bring_state: got %0d want %0d", dut.state_reg, ST_CAPTURE); end
        n_cmp++; if (begin_cap !== 1'b1) begin n_err++; $display("FAIL bring_begin_cap: got %b want 1", begin_cap); end
        $display("bringup: i2c pulses=%0d begin_cap=%b", pulses, begin_cap);
    endtask

    task automatic test_rounds();
        logic [0:0]        exp_rd   [2] = '{1'b0, 1'b1};
        logic [0:0]        exp_wr   [2] = '{1'b1, 1'b0};
        logic [ADDR_W-1:0] offs     [2] = '{30'h80, 30'h40};
        logic [ADDR_W-1:0] exp_addr [2] = '{30'h0010_0080, 30'h0010_0040};
        logic [2:0]        exp_inst [2] = '{3'd0, 3'd1};
        for (int r = 0; r < 2; r++) begin
            click = 1'b1;
            cyc();
            click = 1'b0;
            #1;
            n_cmp++; if (begin_cap !== 1'b0) begin n_err++; $display("FAIL round%0d_drain_cap: got %b want 0", r, begin_cap); end
            done_cap = 1'b1;
            cyc();
            done_cap = 1'b0;
            #1;
            n_cmp++; if (rd_buf !== exp_rd[r]) begin n_err++; $display("FAIL round%0d_rd_buf: got %0d want %0d", r, rd_buf, exp_rd[r]); end
            n_cmp++; if (wr_buf !== exp_wr[r]) begin n_err++; $display("FAIL round%0d_wr_buf: got %0d want %0d", r, wr_buf, exp_wr[r]); end
            n_cmp++; if (begin_read !== 1'b1 || begin_cap !== 1'b1) begin n_err++; $display("FAIL round%0d_send_flags: got read=%b cap=%b want 1/1", r, begin_read, begin_cap); end
            // Round 0 issues a write into the new capture buffer, round 1 a readback.
            w_cmd_en   = (r == 0);
            r_cmd_en   = (r == 1);
            w_cmd_addr = offs[r];
            r_cmd_addr = offs[r];
            w_cmd_bl   = 6'd5;
            r_cmd_bl   = 6'd5;
            click      = 1'b1;
            cyc();
            w_cmd_en = 1'b0;
            r_cmd_en = 1'b0;
            click    = 1'b0;
            #1;
            n_cmp++; if (cmd_en !== 1'b1 || cmd_addr !== exp_addr[r] || cmd_inst !== exp_inst[r] || cmd_bl !== 6'd5)
                begin n_err++; $display("FAIL round%0d_cmd: got en=%b inst=%0d addr=%h bl=%0d want 1/%0d/%h/5", r, cmd_en, cmd_inst, cmd_addr, cmd_bl, exp_inst[r], exp_addr[r]); end
            n_cmp++; if (dut.state_reg !== ST_SEND) begin n_err++; $display("FAIL round%0d_click_ignored: got %0d want %0d", r, dut.state_reg, ST_SEND); end
            cyc();
            #1;
            n_cmp++; if (cmd_en !== 1'b0) begin n_err++; $display("FAIL round%0d_cmd_single: got %b want 0", r, cmd_en); end
            read_done = 1'b1;
            cyc();
            read_done = 1'b0;
            #1;
            n_cmp++; if (begin_read !== 1'b0 || begin_cap !== 1'b1) begin n_err++; $display("FAIL round%0d_back_cap: got read=%b cap=%b want 0/1", r, begin_read, begin_cap); end
            $display("round %0d: rd_buf=%0d wr_buf=%0d cmd_addr=%h", r, exp_rd[r], wr_buf, exp_addr[r]);
        end
`ifdef CAM_FRAME_CTRL_STATS_EN
        n_cmp++; if (frames_captured !== 16'd2 || frames_sent !== 16'd2) begin n_err++; $display("FAIL stats_rounds: got cap=%0d sent=%0d want 2/2", frames_captured, frames_sent); end
`endif
    endtask

    task automatic test_back_to_back();
        // wr_buf=0, rd_buf=1 here
        w_cmd_en = 1'b1; w_cmd_addr = 30'h10; w_cmd_bl = 6'd1;
        r_cmd_en = 1'b1; r_cmd_addr = 30'h20; r_cmd_bl = 6'd2;
        cyc();
        w_cmd_en = 1'b0;
        r_cmd_en = 1'b0;
        #1;
        n_cmp++; if (cmd_en !== 1'b1 || cmd_inst !== 3'd0 || cmd_addr !== 30'h10 || cmd_bl !== 6'd1)
            begin n_err++; $display("FAIL b2b_first: got en=%b inst=%0d addr=%h bl=%0d want 1/0/10/1", cmd_en, cmd_inst, cmd_addr, cmd_bl); end
        cyc();
        #1;
        n_cmp++; if (cmd_en !== 1'b1 || cmd_inst !== 3'd1 || cmd_addr !== 30'h0010_0020 || cmd_bl !== 6'd2)
            begin n_err++; $display("FAIL b2b_second: got en=%b inst=%0d addr=%h bl=%0d want 1/1/100020/2", cmd_en, cmd_inst, cmd_addr, cmd_bl); end
        // Reload the write slot in the cycle it issues.
        w_cmd_en = 1'b1; w_cmd_addr = 30'h30; w_cmd_bl = 6'd3;
        cyc();
        w_cmd_addr = 30'h44; w_cmd_bl = 6'd4;
        #1;
        n_cmp++; if (cmd_en !== 1'b1 || cmd_addr !== 30'h30) begin n_err++; $display("FAIL reload_a: got en=%b addr=%h want 1/30", cmd_en, cmd_addr); end
        cyc();
        w_cmd_en = 1'b0;
        #1;
        n_cmp++; if (cmd_en !== 1'b1 || cmd_addr !== 30'h44 || cmd_bl !== 6'd4) begin n_err++; $display("FAIL reload_b: got en=%b addr=%h bl=%0d want 1/44/4", cmd_en, cmd_addr, cmd_bl); end
        cyc();
        #1;
        n_cmp++; if (cmd_en !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got %b want 0", cmd_en); end
        n_cmp++; if (cmd_ovf !== 1'b0) begin n_err++; $display("FAIL b2b_ovf: got %b want 0", cmd_ovf); end
        $display("back_to_back: write then read issued, ovf=%b", cmd_ovf);
    endtask

    task automatic test_cmd_full();
        cmd_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            w_cmd_en   = (i == 0) || (i == 2);
            w_cmd_addr = (i == 0) ? 30'h100 : 30'h200;
            w_cmd_bl   = 6'd7;
            #1;
            n_cmp++; if (cmd_en !== 1'b0) begin n_err++; $display("FAIL full_hold%0d: got %b want 0", i, cmd_en); end
            cyc();
        end
        w_cmd_en = 1'b0;
        n_cmp++; if (cmd_ovf !== 1'b1) begin n_err++; $display("FAIL full_ovf: got %b want 1", cmd_ovf); end
        cmd_full = 1'b0;
        #1;
        n_cmp++; if (cmd_en !== 1'b1 || cmd_inst !== 3'd0 || cmd_addr !== 30'h100 || cmd_bl !== 6'd7)
            begin n_err++; $display("FAIL full_release: got en=%b inst=%0d addr=%h bl=%0d want 1/0/100/7", cmd_en, cmd_inst, cmd_addr, cmd_bl); end
        cyc();
        #1;
        n_cmp++; if (cmd_en !== 1'b0) begin n_err++; $display("FAIL full_dropped: got %b want 0", cmd_en); end
        $display("cmd_full: first write at %h, ovf=%b", 30'h100, cmd_ovf);
    endtask

    task automatic test_reset_mid();
        click = 1'b1;
        cyc();
        click = 1'b0;
        done_cap = 1'b1;
        cyc();
        done_cap = 1'b0;
        cmd_full = 1'b1;
        r_cmd_en = 1'b1; r_cmd_addr = 30'h8; r_cmd_bl = 6'd1;
        cyc();
        r_cmd_en = 1'b0;
        #1;
        n_cmp++; if (dut.state_reg !== ST_SEND || cmd_en !== 1'b0) begin n_err++; $display("FAIL mid_pending: got state=%0d en=%b want %0d/0", dut.state_reg, cmd_en, ST_SEND); end
        reset = 1'b1;
        cmd_full = 1'b0;
        #1;
        n_cmp++; if (cmd_en !== 1'b0) begin n_err++; $display("FAIL mid_rst_cycle: got %b want 0", cmd_en); end
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (cmd_en !== 1'b0) begin n_err++; $display("FAIL mid_after%0d: got %b want 0", i, cmd_en); end
            cyc();
        end
        n_cmp++; if (dut.state_reg !== ST_IDLE) begin n_err++; $display("FAIL mid_state: got %0d want %0d", dut.state_reg, ST_IDLE); end
        n_cmp++; if (ram_reset !== 1'b1 || begin_read !== 1'b0 || cmd_ovf !== 1'b0) begin n_err++; $display("FAIL mid_outputs: got ram=%b read=%b ovf=%b want 1/0/0", ram_reset, begin_read, cmd_ovf); end
`ifdef CAM_FRAME_CTRL_STATS_EN
        n_cmp++; if (frames_captured !== 16'd0) begin n_err++; $display("FAIL mid_stats: got %0d want 0", frames_captured); end
`endif
        $display("reset_mid: state=%0d ram_reset=%b", dut.state_reg, ram_reset);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; calib_done = 1'b0; i2c_done = 1'b0;
        click = 1'b0; done_cap = 1'b0; read_done = 1'b0; cmd_full = 1'b0;
        w_cmd_en = 1'b0; w_cmd_bl = '0; w_cmd_addr = '0;
        r_cmd_en = 1'b0; r_cmd_bl = '0; r_cmd_addr = '0;
        test_reset();
        test_bringup();
        test_rounds();
        test_back_to_back();
        test_cmd_full();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
